// File: rtl/csi_sequence_parser_if.sv
// ---------------------------------------------------------------------------
// csi_sequence_parser_if
// Byte-stream input and classified-command output of the escape/CSI parser.
//
//   data_valid / data / in_ready        host byte stream (valid/ready)
//   cmd_valid / cmd_ready               command handshake (valid/ready)
//   cmd_kind                            0 PRINT, 1 C0, 2 ESC, 3 CSI
//   cmd_final                           printable / control / final byte
//   cmd_private                         CSI private marker, 0 if none
//   cmd_inter                           last intermediate byte, 0 if none
//   cmd_nparams                         number of parameters present
//   cmd_params                          param i at [i*PARAM_W +: PARAM_W]
//   cmd_overflow                        params dropped or saturated
//
// Modports: master = byte source / command sink, slave = the parser.
// ---------------------------------------------------------------------------
interface csi_sequence_parser_if #(
    parameter int MAX_PARAMS = 16,
    parameter int PARAM_W    = 16
);
    localparam int NP_W = $clog2(MAX_PARAMS + 1);

    logic                          data_valid;
    logic [7:0]                    data;
    logic                          in_ready;
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [2:0]                    cmd_kind;
    logic [7:0]                    cmd_final;
    logic [7:0]                    cmd_private;
    logic [7:0]                    cmd_inter;
    logic [NP_W-1:0]               cmd_nparams;
    logic [MAX_PARAMS*PARAM_W-1:0] cmd_params;
    logic                          cmd_overflow;

    modport master (
        output data_valid, data, cmd_ready,
        input  in_ready, cmd_valid, cmd_kind, cmd_final, cmd_private,
               cmd_inter, cmd_nparams, cmd_params, cmd_overflow
    );

    modport slave (
        input  data_valid, data, cmd_ready,
        output in_ready, cmd_valid, cmd_kind, cmd_final, cmd_private,
               cmd_inter, cmd_nparams, cmd_params, cmd_overflow
    );
endinterface

// File: rtl/csi_sequence_parser.sv
// ---------------------------------------------------------------------------
// csi_sequence_parser
// Splits a raw host byte stream into one classified command per printable
// char, C0 control, ESC sequence or CSI sequence. CSI sequences carry up to
// MAX_PARAMS decimal parameters of PARAM_W bits each, plus private marker,
// last intermediate and an overflow flag. Commands are held on a valid/ready
// handshake; no input byte is taken while a command is pending.
//
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   csi_sequence_parser_if.slave (byte input + command output)
//
// state       | meaning
// ------------+--------------------------------------------------------
// GROUND      | idle, printable / C0 bytes emitted directly
// ESCAPE      | ESC seen, waiting for '[', intermediate or final
// ESC_INTER   | ESC with intermediate(s), waiting for final
// CSI_ENTRY   | "ESC [" seen, nothing else yet
// CSI_PARAM   | collecting digits / ';' separators
// CSI_INTER   | CSI intermediate(s) seen, waiting for final
// CSI_IGNORE  | malformed CSI, swallowing up to its final byte
// ---------------------------------------------------------------------------
module csi_sequence_parser #(
    parameter int MAX_PARAMS    = 16,
    parameter int PARAM_W       = 16,
    parameter int PARAM_DEFAULT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    csi_sequence_parser_if.slave  bus
);
    localparam int NP_W = $clog2(MAX_PARAMS + 1);
    localparam int PV_W = MAX_PARAMS * PARAM_W;
    localparam int PR_W = PARAM_W + 5;   // wide enough for cur*10 + 9

    localparam logic [PARAM_W-1:0] DEF_P = PARAM_W'(PARAM_DEFAULT);
    localparam logic [PARAM_W-1:0] SAT_P = '1;
    localparam logic [PV_W-1:0]    DEF_V = {MAX_PARAMS{DEF_P}};

    localparam logic [2:0] K_PRINT = 3'd0;
    localparam logic [2:0] K_C0    = 3'd1;
    localparam logic [2:0] K_ESC   = 3'd2;
    localparam logic [2:0] K_CSI   = 3'd3;

    typedef enum logic [2:0] {
        S_GROUND,
        S_ESCAPE,
        S_ESC_INTER,
        S_CSI_ENTRY,
        S_CSI_PARAM,
        S_CSI_INTER,
        S_CSI_IGNORE
    } state_t;

    // sequence state
    state_t            state_q, state_d;
    logic [PARAM_W-1:0] cur_q, cur_d;
    logic              has_digit_q, has_digit_d;
    logic              any_param_q, any_param_d;
    logic [NP_W-1:0]   cnt_q, cnt_d;
    logic [PV_W-1:0]   params_q, params_d;
    logic [7:0]        priv_q, priv_d;
    logic [7:0]        inter_q, inter_d;
    logic              ovf_q, ovf_d;

    // command output registers
    logic              cmd_valid_q, cmd_valid_d;
    logic [2:0]        cmd_kind_q, cmd_kind_d;
    logic [7:0]        cmd_final_q, cmd_final_d;
    logic [7:0]        cmd_private_q, cmd_private_d;
    logic [7:0]        cmd_inter_q, cmd_inter_d;
    logic [NP_W-1:0]   cmd_nparams_q, cmd_nparams_d;
    logic [PV_W-1:0]   cmd_params_q, cmd_params_d;
    logic              cmd_overflow_q, cmd_overflow_d;

    logic              accept;
    logic [7:0]        b;
    logic              do_clear, do_digit, do_sep, do_csi, do_esc, do_simple;
    logic              do_commit;
    logic [2:0]        simple_kind;
    logic [PR_W-1:0]   prod;
    logic [PARAM_W-1:0] commit_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_GROUND;
            cur_q          <= '0;
            has_digit_q    <= 1'b0;
            any_param_q    <= 1'b0;
            cnt_q          <= '0;
            params_q       <= DEF_V;
            priv_q         <= '0;
            inter_q        <= '0;
            ovf_q          <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_kind_q     <= '0;
            cmd_final_q    <= '0;
            cmd_private_q  <= '0;
            cmd_inter_q    <= '0;
            cmd_nparams_q  <= '0;
            cmd_params_q   <= '0;
            cmd_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            has_digit_q    <= has_digit_d;
            any_param_q    <= any_param_d;
            cnt_q          <= cnt_d;
            params_q       <= params_d;
            priv_q         <= priv_d;
            inter_q        <= inter_d;
            ovf_q          <= ovf_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_kind_q     <= cmd_kind_d;
            cmd_final_q    <= cmd_final_d;
            cmd_private_q  <= cmd_private_d;
            cmd_inter_q    <= cmd_inter_d;
            cmd_nparams_q  <= cmd_nparams_d;
            cmd_params_q   <= cmd_params_d;
            cmd_overflow_q <= cmd_overflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        has_digit_d    = has_digit_q;
        any_param_d    = any_param_q;
        cnt_d          = cnt_q;
        params_d       = params_q;
        priv_d         = priv_q;
        inter_d        = inter_q;
        ovf_d          = ovf_q;
        cmd_valid_d    = cmd_valid_q;
        cmd_kind_d     = cmd_kind_q;
        cmd_final_d    = cmd_final_q;
        cmd_private_d  = cmd_private_q;
        cmd_inter_d    = cmd_inter_q;
        cmd_nparams_d  = cmd_nparams_q;
        cmd_params_d   = cmd_params_q;
        cmd_overflow_d = cmd_overflow_q;

        do_clear    = 1'b0;
        do_digit    = 1'b0;
        do_sep      = 1'b0;
        do_csi      = 1'b0;
        do_esc      = 1'b0;
        do_simple   = 1'b0;
        simple_kind = K_PRINT;

        b      = bus.data;
        accept = bus.data_valid && !cmd_valid_q;

        // ---------------- byte classification ----------------
        if (accept) begin
            if (state_q == S_GROUND) begin
                if (b == 8'h1B) begin
                    state_d  = S_ESCAPE;
                    do_clear = 1'b1;
                end else if (b < 8'h20) begin
                    do_simple   = 1'b1;
                    simple_kind = K_C0;
                end else if (b != 8'h7F) begin
                    do_simple   = 1'b1;
                    simple_kind = K_PRINT;
                end
            end else if (b == 8'h18 || b == 8'h1A) begin
                state_d = S_GROUND;
            end else if (b == 8'h1B) begin
                state_d  = S_ESCAPE;
                do_clear = 1'b1;
            end else if (b < 8'h20) begin
                // C0 inside a sequence: emitted, sequence state untouched
                do_simple   = 1'b1;
                simple_kind = K_C0;
            end else if (b != 8'h7F) begin
                // b is 0x20..0xFF here; bytes >= 0x80 are dropped in sequences
                case (state_q)
                    S_ESCAPE, S_ESC_INTER: begin
                        if (state_q == S_ESCAPE && b == 8'h5B) begin
                            state_d  = S_CSI_ENTRY;
                            do_clear = 1'b1;
                        end else if (b <= 8'h2F) begin
                            inter_d = b;
                            state_d = S_ESC_INTER;
                        end else if (b <= 8'h7E) begin
                            do_esc  = 1'b1;
                            state_d = S_GROUND;
                        end
                    end
                    S_CSI_ENTRY, S_CSI_PARAM: begin
                        if (b >= 8'h30 && b <= 8'h39) begin
                            do_digit = 1'b1;
                            state_d  = S_CSI_PARAM;
                        end else if (b == 8'h3B) begin
                            do_sep  = 1'b1;
                            state_d = S_CSI_PARAM;
                        end else if (b == 8'h3A) begin
                            state_d = S_CSI_IGNORE;
                        end else if (b >= 8'h3C && b <= 8'h3F) begin
                            // private marker only legal as the first byte
                            if (state_q == S_CSI_ENTRY) begin
                                priv_d  = b;
                                state_d = S_CSI_PARAM;
                            end else begin
                                state_d = S_CSI_IGNORE;
                            end
                        end else if (b <= 8'h2F) begin
                            inter_d = b;
                            state_d = S_CSI_INTER;
                        end else if (b <= 8'h7E) begin
                            do_csi  = 1'b1;
                            state_d = S_GROUND;
                        end
                    end
                    S_CSI_INTER: begin
                        if (b <= 8'h2F) begin
                            inter_d = b;
                        end else if (b <= 8'h3F) begin
                            state_d = S_CSI_IGNORE;
                        end else if (b <= 8'h7E) begin
                            do_csi  = 1'b1;
                            state_d = S_GROUND;
                        end
                    end
                    S_CSI_IGNORE: begin
                        if (b >= 8'h40 && b <= 8'h7E) begin
                            state_d = S_GROUND;
                        end
                    end
                    default: state_d = S_GROUND;
                endcase
            end
        end

        // ---------------- sequence datapath ----------------
        if (do_clear) begin
            cur_d       = '0;
            has_digit_d = 1'b0;
            any_param_d = 1'b0;
            cnt_d       = '0;
            params_d    = DEF_V;
            priv_d      = '0;
            inter_d     = '0;
            ovf_d       = 1'b0;
        end

        prod = PR_W'(cur_q) * PR_W'(10) + PR_W'(b[3:0]);
        if (do_digit) begin
            any_param_d = 1'b1;
            has_digit_d = 1'b1;
            if (prod[PR_W-1:PARAM_W] != '0) begin
                cur_d = SAT_P;
                ovf_d = 1'b1;
            end else begin
                cur_d = prod[PARAM_W-1:0];
            end
        end

        // The final byte commits the open parameter only if any digit or ';'
        // was seen, so "ESC [ m" reports zero params.
        do_commit  = do_sep || (do_csi && any_param_q);
        commit_val = has_digit_q ? cur_q : DEF_P;
        if (do_commit) begin
            if (cnt_q < NP_W'(MAX_PARAMS)) begin
                for (int i = 0; i < MAX_PARAMS; i++) begin
                    if (NP_W'(i) == cnt_q) begin
                        params_d[i*PARAM_W +: PARAM_W] = commit_val;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
            cur_d       = '0;
            has_digit_d = 1'b0;
        end
        if (do_sep) begin
            any_param_d = 1'b1;
        end

        // ---------------- command output ----------------
        if (cmd_valid_q && bus.cmd_ready) begin
            cmd_valid_d = 1'b0;
        end

        if (do_simple || do_esc) begin
            cmd_valid_d    = 1'b1;
            cmd_kind_d     = do_esc ? K_ESC : simple_kind;
            cmd_final_d    = b;
            cmd_private_d  = '0;
            cmd_inter_d    = do_esc ? inter_q : 8'h00;
            cmd_nparams_d  = '0;
            cmd_params_d   = DEF_V;
            cmd_overflow_d = 1'b0;
        end

        if (do_csi) begin
            cmd_valid_d    = 1'b1;
            cmd_kind_d     = K_CSI;
            cmd_final_d    = b;
            cmd_private_d  = priv_q;
            cmd_inter_d    = inter_q;
            cmd_nparams_d  = any_param_q ? cnt_d : '0;
            cmd_params_d   = params_d;
            cmd_overflow_d = ovf_d;
        end
    end

    assign bus.in_ready     = !cmd_valid_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_kind     = cmd_kind_q;
    assign bus.cmd_final    = cmd_final_q;
    assign bus.cmd_private  = cmd_private_q;
    assign bus.cmd_inter    = cmd_inter_q;
    assign bus.cmd_nparams  = cmd_nparams_q;
    assign bus.cmd_params   = cmd_params_q;
    assign bus.cmd_overflow = cmd_overflow_q;

endmodule

// File: tb/tb_csi_sequence_parser.sv
// ---------------------------------------------------------------------------
// tb_csi_sequence_parser
// Directed bench for csi_sequence_parser with MAX_PARAMS=16, PARAM_W=16,
// PARAM_DEFAULT=0. All tasks start and end on a falling clock edge.
// ---------------------------------------------------------------------------
module tb_csi_sequence_parser;
    localparam int MP = 16;
    localparam int PW = 16;
    localparam int PD = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csi_sequence_parser_if #(.MAX_PARAMS(MP), .PARAM_W(PW)) bus ();

    csi_sequence_parser #(
        .MAX_PARAMS   (MP),
        .PARAM_W      (PW),
        .PARAM_DEFAULT(PD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkp(input int n, input int v0, input int v1, input int v2);
        logic [255:0] r;
        r = {MP{16'(PD)}};
        if (n > 0) r[15:0]  = 16'(v0);
        if (n > 1) r[31:16] = 16'(v1);
        if (n > 2) r[47:32] = 16'(v2);
        return r;
    endfunction

    task automatic send(input logic [7:0] v);
        int t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_in_ready", 256'(bus.in_ready), 256'(1));
        bus.data_valid = 1'b1;
        bus.data       = v;
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic expect_cmd(input string tag, input int kind, input int fin,
                              input int priv, input int inter, input int np,
                              input int ovf, input logic [255:0] prm);
        int t = 0;
        while (bus.cmd_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"},   256'(bus.cmd_valid), 256'(1));
        chk({tag, "_kind"},    256'(bus.cmd_kind), 256'(kind));
        chk({tag, "_final"},   256'(bus.cmd_final), 256'(fin));
        chk({tag, "_private"}, 256'(bus.cmd_private), 256'(priv));
        chk({tag, "_inter"},   256'(bus.cmd_inter), 256'(inter));
        chk({tag, "_nparams"}, 256'(bus.cmd_nparams), 256'(np));
        chk({tag, "_ovf"},     256'(bus.cmd_overflow), 256'(ovf));
        chk({tag, "_params"},  bus.cmd_params, prm);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        chk({tag, "_drop"},    256'(bus.cmd_valid), 256'(0));
        chk({tag, "_inrdy"},   256'(bus.in_ready), 256'(1));
    endtask

    initial begin
        logic [255:0] p18;

        rst            = 1'b1;
        bus.data_valid = 1'b0;
        bus.data       = 8'h00;
        bus.cmd_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid",   256'(bus.cmd_valid), 256'(0));
        chk("rst_inrdy",   256'(bus.in_ready), 256'(1));
        chk("rst_kind",    256'(bus.cmd_kind), 256'(0));
        chk("rst_final",   256'(bus.cmd_final), 256'(0));
        chk("rst_nparams", 256'(bus.cmd_nparams), 256'(0));
        chk("rst_params",  bus.cmd_params, 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // reset in the middle of "ESC [ 1 2"
        send(8'h1B); send_str("[12");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_inrdy", 256'(bus.in_ready), 256'(1));
        chk("midrst_valid", 256'(bus.cmd_valid), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        send_str("A");
        expect_cmd("midrst_A", 0, 8'h41, 0, 0, 0, 0, mkp(0, 0, 0, 0));

        // empty middle parameter, valid one cycle after the final byte
        send(8'h1B); send_str("[3;;15H");
        chk("csi3_latency", 256'(bus.cmd_valid), 256'(1));
        expect_cmd("csi3", 3, 8'h48, 0, 0, 3, 0, mkp(3, 3, PD, 15));

        // private marker with downstream stall; 'Z' offered during the stall
        send(8'h1B); send_str("[?25l");
        bus.data_valid = 1'b1;
        bus.data       = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            chk("stall_inrdy", 256'(bus.in_ready), 256'(0));
            chk("stall_valid", 256'(bus.cmd_valid), 256'(1));
            chk("stall_final", 256'(bus.cmd_final), 256'(8'h6C));
            chk("stall_priv",  256'(bus.cmd_private), 256'(8'h3F));
            @(negedge clk);
        end
        chk("stall_kind",    256'(bus.cmd_kind), 256'(3));
        chk("stall_nparams", 256'(bus.cmd_nparams), 256'(1));
        chk("stall_params",  bus.cmd_params, mkp(1, 25, 0, 0));
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        chk("stall_drop", 256'(bus.cmd_valid), 256'(0));
        @(negedge clk);
        bus.data_valid = 1'b0;
        expect_cmd("after_stall_Z", 0, 8'h5A, 0, 0, 0, 0, mkp(0, 0, 0, 0));

        // 18 parameters: last two dropped
        send(8'h1B); send_str("[");
        for (int k = 1; k <= 18; k++) begin
            if (k >= 10) send(8'(8'h30 + k / 10));
            send(8'(8'h30 + k % 10));
            if (k != 18) send_str(";");
        end
        send_str("m");
        p18 = '0;
        for (int i = 0; i < 16; i++) p18[i*16 +: 16] = 16'(i + 1);
        expect_cmd("p18", 3, 8'h6D, 0, 0, 16, 1, p18);

        // saturation
        send(8'h1B); send_str("[99999A");
        expect_cmd("sat", 3, 8'h41, 0, 0, 1, 1, mkp(1, 65535, 0, 0));

        // C0 inside a CSI sequence
        send(8'h1B); send_str("[1"); send(8'h0A);
        expect_cmd("lf_c0", 1, 8'h0A, 0, 0, 0, 0, mkp(0, 0, 0, 0));
        send_str("2m");
        expect_cmd("lf_csi", 3, 8'h6D, 0, 0, 1, 0, mkp(1, 12, 0, 0));

        // CAN aborts
        send(8'h1B); send_str("[1"); send(8'h18);
        @(negedge clk);
        chk("can_noemit", 256'(bus.cmd_valid), 256'(0));
        send_str("Q");
        expect_cmd("can_Q", 0, 8'h51, 0, 0, 0, 0, mkp(0, 0, 0, 0));

        // ESC with intermediate
        send(8'h1B); send_str("(B");
        expect_cmd("esc_inter", 2, 8'h42, 0, 8'h28, 0, 0, mkp(0, 0, 0, 0));

        // colon sub-parameter -> ignored sequence
        send(8'h1B); send_str("[1:2m");
        @(negedge clk);
        chk("colon_noemit", 256'(bus.cmd_valid), 256'(0));
        send_str("X");
        expect_cmd("colon_X", 0, 8'h58, 0, 0, 0, 0, mkp(0, 0, 0, 0));

        // GROUND C0, DEL dropped, high byte printable
        send(8'h07);
        expect_cmd("bel", 1, 8'h07, 0, 0, 0, 0, mkp(0, 0, 0, 0));
        send(8'h7F);
        @(negedge clk);
        chk("del_noemit", 256'(bus.cmd_valid), 256'(0));
        send(8'h80);
        expect_cmd("hi80", 0, 8'h80, 0, 0, 0, 0, mkp(0, 0, 0, 0));

        // no params; private + intermediate
        send(8'h1B); send_str("[m");
        expect_cmd("csi_empty", 3, 8'h6D, 0, 0, 0, 0, mkp(0, 0, 0, 0));
        send(8'h1B); send_str("[>5$p");
        expect_cmd("csi_pi", 3, 8'h70, 8'h3E, 8'h24, 1, 0, mkp(1, 5, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
